// File: rtl/jelly_cpu_hilo_unit.sv
// HI/LO register unit: MTHI/MTLO writes, divide hand-off to jelly_cpu_divider,
// iterative shift-add multiply when JELLY_CPU_HILO_MULT_EN is defined.
module jelly_cpu_hilo_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic [2:0]            in_op,
  input  logic                  in_read,
  input  logic [DATA_WIDTH-1:0] in_data0,
  input  logic [DATA_WIDTH-1:0] in_data1,

  output logic [DATA_WIDTH-1:0] out_hi,
  output logic [DATA_WIDTH-1:0] out_lo,
  output logic                  out_stall,
  output logic                  out_done,
  output logic                  out_illegal,

  output logic                  div_op_div,
  output logic                  div_op_signed,
  output logic [DATA_WIDTH-1:0] div_data0,
  output logic [DATA_WIDTH-1:0] div_data1,
  input  logic                  div_out_en,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic [DATA_WIDTH-1:0] div_remainder,
  input  logic                  div_busy
);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DIV_ISSUE = 2'd1,
    ST_DIV_WAIT  = 2'd2,
    ST_MUL_RUN   = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   op_valid;

  assign op_valid = (in_op != OP_NONE) && (in_op != 3'd7);

`ifdef JELLY_CPU_HILO_MULT_EN
  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [CNT_W-1:0]        mul_cnt;
  logic                    mul_neg;
  logic [DATA_WIDTH-1:0]   mul_mplier;
  logic [2*DATA_WIDTH-1:0] mul_mcand;
  logic [2*DATA_WIDTH-1:0] mul_acc;
  logic [2*DATA_WIDTH-1:0] mul_sum;
  logic                    mul_last;
  logic                    mul_signed;
  logic [DATA_WIDTH-1:0]   mul_abs0;
  logic [DATA_WIDTH-1:0]   mul_abs1;

  assign mul_signed = (in_op == OP_MULT);
  // -MIN fits as an unsigned magnitude, so no special case is needed
  assign mul_abs0   = (mul_signed && in_data0[DATA_WIDTH-1]) ? -in_data0 : in_data0;
  assign mul_abs1   = (mul_signed && in_data1[DATA_WIDTH-1]) ? -in_data1 : in_data1;
  assign mul_sum    = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  assign mul_last   = (mul_cnt == CNT_W'(DATA_WIDTH - 1));
`endif

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (in_op == OP_DIV || in_op == OP_DIVU) state_nxt = ST_DIV_ISSUE;
`ifdef JELLY_CPU_HILO_MULT_EN
        if (in_op == OP_MULT || in_op == OP_MULTU) state_nxt = ST_MUL_RUN;
`endif
      end
      ST_DIV_ISSUE: if (!div_busy)  state_nxt = ST_DIV_WAIT;
      ST_DIV_WAIT:  if (div_out_en) state_nxt = ST_IDLE;
`ifdef JELLY_CPU_HILO_MULT_EN
      ST_MUL_RUN:   if (mul_last)   state_nxt = ST_IDLE;
`endif
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // combinational outputs
  always_comb begin
    div_op_div = (state == ST_DIV_ISSUE) && !div_busy;
    out_stall  = (state != ST_IDLE) && (op_valid || in_read);
  end

  // datapath: HI/LO, divider operand latches, multiply engine, pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_hi        <= '0;
      out_lo        <= '0;
      out_done      <= 1'b0;
      out_illegal   <= 1'b0;
      div_op_signed <= 1'b0;
      div_data0     <= '0;
      div_data1     <= '0;
`ifdef JELLY_CPU_HILO_MULT_EN
      mul_cnt       <= '0;
      mul_neg       <= 1'b0;
      mul_mplier    <= '0;
      mul_mcand     <= '0;
      mul_acc       <= '0;
`endif
    end else begin
      out_done    <= 1'b0;
      out_illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          case (in_op)
            OP_MTHI: out_hi <= in_data0;
            OP_MTLO: out_lo <= in_data0;
            OP_DIV, OP_DIVU: begin
              div_op_signed <= (in_op == OP_DIV);
              div_data0     <= in_data0;
              div_data1     <= in_data1;
            end
            OP_MULT, OP_MULTU: begin
`ifdef JELLY_CPU_HILO_MULT_EN
              mul_neg    <= mul_signed && (in_data0[DATA_WIDTH-1] ^ in_data1[DATA_WIDTH-1]);
              mul_mcand  <= {{DATA_WIDTH{1'b0}}, mul_abs0};
              mul_mplier <= mul_abs1;
              mul_acc    <= '0;
              mul_cnt    <= '0;
`else
              out_illegal <= 1'b1;
`endif
            end
            default: ;
          endcase
        end
        ST_DIV_WAIT: begin
          if (div_out_en) begin
            out_lo        <= div_quotient;
            out_hi        <= div_remainder;
            out_done      <= 1'b1;
            div_op_signed <= 1'b0;
            div_data0     <= '0;
            div_data1     <= '0;
          end
        end
`ifdef JELLY_CPU_HILO_MULT_EN
        ST_MUL_RUN: begin
          mul_acc    <= mul_sum;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_cnt    <= mul_cnt + CNT_W'(1);
          if (mul_last) begin
            {out_hi, out_lo} <= mul_neg ? -mul_sum : mul_sum;
            out_done         <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/jelly_cpu_hilo_unit.md
# jelly_cpu_hilo_unit

HI/LO register unit for the MIPS-like core. It sits between the EX stage and `jelly_cpu_divider`:
- It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX.
- It hands divide work to the divider and captures quotient into LO and remainder into HI.
- Multiply runs on an internal iterative shift-add engine that writes the 64-bit product into {HI,LO}.
- It stalls the pipeline while a multi-cycle operation is in flight.

## Interface
- `DATA_WIDTH`, 32, operand/HI/LO width (even, ≥8)
- `clk`  in  1  clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_op`  in  3  000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (NONE)
- `in_read`  in  1  EX holds MFHI/MFLO this cycle
- `in_data0`  in  DATA_WIDTH  rs operand (dividend / multiplicand / MT source)
- `in_data1`  in  DATA_WIDTH  rt operand (divisor / multiplier)
- `out_hi`, `out_lo`  out  DATA_WIDTH  registered HI/LO
- `out_stall`  out  1  combinational: state≠IDLE and (in_op≠NONE or in_read)
- `out_done`  out  1  one-cycle pulse when a MULT/DIV result is written
- `out_illegal`  out  1  one-cycle pulse, see Configuration
- `div_op_div`, `div_op_signed`  out  1  request to divider
- `div_data0`, `div_data1`  out  DATA_WIDTH  divider operands
- `div_out_en`  in  1  divider result valid pulse
- `div_quotient`, `div_remainder`  in  DATA_WIDTH  divider results
- `div_busy`  in  1  divider busy

## Operation
- States:
  - IDLE
  - DIV_ISSUE
  - DIV_WAIT
  - MUL_RUN
- IDLE accepts `in_op`≠NONE at the rising edge:
  - MTHI/MTLO: write `in_data0` into HI/LO, stay in IDLE.
  - DIV/DIVU: latch operands and signedness into `div_data*`/`div_op_signed`, go to DIV_ISSUE.
  - MULT/MULTU: latch magnitudes (`abs` if signed), product sign = signed & (msb0^msb1), counter←0, accumulator←0, go to MUL_RUN.
- DIV_ISSUE:
  - `div_op_div` = !`div_busy` (registered-state decode).
  - On a cycle with `div_op_div`=1, go to DIV_WAIT.
  - While `div_busy`=1, wait; no request is dropped.
- DIV_WAIT:
  - On `div_out_en`: LO←`div_quotient`, HI←`div_remainder`, `out_done` pulse, go to IDLE.
  - `div_out_en` is ignored in every other state.
- MUL_RUN:
  - One shift-add step per cycle for DATA_WIDTH cycles.
  - On the last step, {HI,LO}←product, two's-complement negated over 2·DATA_WIDTH bits if the sign is set.
  - Pulse `out_done`, go to IDLE.
- Requests arriving while state≠IDLE are not accepted; EX holds them under `out_stall`.
- Divide by zero: divider result is written unmodified; no exception.
- `div_op_div`, `div_op_signed`, `div_data*` are 0 whenever state≠DIV_ISSUE/DIV_WAIT.

## Timing
- Reset values (asynchronous, immediate):
  - `out_hi`=`out_lo`=0, state IDLE.
  - `out_done`=`out_illegal`=0, `div_op_div`=0, `div_data*`=0.
- MTHI/MTLO accepted at edge T: new value on `out_hi`/`out_lo` after T.
- MULT accepted at edge T:
  - MUL_RUN occupies T..T+DATA_WIDTH−1.
  - HI/LO valid and `out_done`=1 after edge T+DATA_WIDTH.
  - Back to IDLE at that same edge.
- DIV accepted at edge T:
  - `div_op_div`=1 during cycle T+1 (if divider idle).
  - Result written on the edge where `div_out_en`=1; `out_done` high the following cycle.
- Simultaneous `div_out_en` and new `in_op`: the result is written, and the op stays stalled until IDLE.
- Reset mid-operation: the op is aborted and HI/LO are zeroed.
  - A stale `div_out_en` from the divider after reset is ignored (state IDLE).
  - A later DIV waits in DIV_ISSUE until `div_busy`=0.

## Configuration
- `JELLY_CPU_HILO_MULT_EN` defined: multiply engine built, MULT/MULTU as above, `out_illegal` tied 0.
- Undefined: no multiply datapath.
  - MULT/MULTU are accepted in IDLE, HI/LO unchanged, no stall.
  - `out_illegal` pulses for one cycle after the accept edge; `out_done` stays 0.

## Test plan
- DIV 7, −3 (0x00000007, 0xFFFFFFFD) → LO=0xFFFFFFFE, HI=0x00000001, one `out_done`, `out_stall` high on an in-flight MFLO until done.
- DIVU 0xFFFFFFFF, 0x00000010 → LO=0x0FFFFFFF, HI=0x0000000F; DIV −7, 3 → LO=0xFFFFFFFE, HI=0xFFFFFFFF.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 exactly 32 edges after accept; MULT −2 × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MTHI 0x12345678 issued during MUL_RUN → stall until done, then HI=0x12345678 one edge after accept.
- Hold `div_busy`=1 for 5 cycles at issue → `div_op_div` stays 0, asserts once busy drops, exactly one request.
- Assert `reset_n`=0 mid-DIV, release, inject `div_out_en` → HI=LO=0 unchanged; build without `JELLY_CPU_HILO_MULT_EN`: MULT → `out_illegal` single pulse, HI/LO unchanged.
